mult_job_scheduler: RTL and testbench

- Shares one pipelined 64x64 multiplier among NUM_REQ requesters, each presenting an operand pair plus a destination cache-line address.
- Round-robin arbitration feeds the multiplier; results are buffered, then issued as single-line write requests toward the c1 TX channel, throttled by c1 almost-full.
- Sits between the CSR-driven job sources and the MPF write path.

---
 rtl/mult_job_scheduler.sv | 151 +++++++++++++++
 tb/tb_mult_job_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_job_scheduler.sv
// Shares one pipelined 64x64 multiplier among NUM_REQ requesters with round-robin
// arbitration, credit-limited result buffering and registered c1 write issue.
module mult_job_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int MULT_LAT  = 3,
    parameter int RES_DEPTH = 8,
    parameter int ADDR_W    = 42
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*64-1:0]        req_a,
    input  logic [NUM_REQ*64-1:0]        req_b,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic                         c1_alm_full,
    output logic                         wr_valid,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [511:0]                 wr_data,
    output logic [$clog2(NUM_REQ)-1:0]   wr_req_id,
    output logic                         busy,
    output logic [31:0]                  jobs_done
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int PIPE_N = (MULT_LAT > 1) ? MULT_LAT - 1 : 1;
    localparam int PTR_W  = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RES_DEPTH + 1);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [63:0]       prod;
    } job_t;

    logic [ID_W-1:0]   rr_q, rr_d;
    logic [PIPE_N-1:0] pipe_vld_q, pipe_vld_d;
    job_t              pipe_job_q [PIPE_N];
    job_t              pipe_job_d [PIPE_N];
    job_t              fifo_mem_q [RES_DEPTH];
    job_t              fifo_mem_d [RES_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic              wr_valid_q, wr_valid_d;
    job_t              wr_job_q, wr_job_d;
    logic [31:0]       jobs_done_q, jobs_done_d;

    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   cand;
    int unsigned       outstanding;
    logic              credit_ok;
    logic              accept;
    job_t              stage0_job;
    logic              push_vld;
    job_t              push_job;
    logic              pop;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((32'(rr_q) + i) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Credit counts every job past the accept stage, so the FIFO can never overflow.
    always_comb begin
        outstanding = 32'(fifo_cnt_q);
        for (int unsigned k = 0; k < PIPE_N; k++) begin
            if (MULT_LAT > 1 && pipe_vld_q[k]) outstanding = outstanding + 1;
        end
        credit_ok = outstanding < RES_DEPTH;
        accept    = gnt_found && credit_ok && !reset;
        req_ready = '0;
        if (accept) req_ready[gnt_idx] = 1'b1;
        stage0_job.id   = gnt_idx;
        stage0_job.addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
        stage0_job.prod = req_a[gnt_idx*64 +: 64] * req_b[gnt_idx*64 +: 64];
        rr_d = rr_q;
        if (accept) rr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // The FIFO write itself is the last multiplier stage, hence MULT_LAT-1 pipe registers.
    always_comb begin
        pipe_vld_d    = (pipe_vld_q << 1) | PIPE_N'(accept);
        pipe_job_d[0] = stage0_job;
        for (int unsigned k = 1; k < PIPE_N; k++) pipe_job_d[k] = pipe_job_q[k-1];
        if (MULT_LAT > 1) begin
            push_vld = pipe_vld_q[PIPE_N-1];
            push_job = pipe_job_q[PIPE_N-1];
        end else begin
            push_vld = accept;
            push_job = stage0_job;
        end

        pop        = (fifo_cnt_q != '0) && !c1_alm_full;
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push_vld) begin
            fifo_mem_d[wr_ptr_q] = push_job;
            wr_ptr_d = (wr_ptr_q == PTR_W'(RES_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = (rd_ptr_q == PTR_W'(RES_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push_vld) - CNT_W'(pop);

        wr_valid_d  = pop;
        wr_job_d    = pop ? fifo_mem_q[rd_ptr_q] : wr_job_q;
        jobs_done_d = jobs_done_q + 32'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q        <= '0;
            pipe_vld_q  <= '0;
            for (int unsigned k = 0; k < PIPE_N; k++) pipe_job_q[k] <= '0;
            for (int unsigned k = 0; k < RES_DEPTH; k++) fifo_mem_q[k] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            wr_valid_q  <= 1'b0;
            wr_job_q    <= '0;
            jobs_done_q <= '0;
        end else begin
            rr_q        <= rr_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_job_q  <= pipe_job_d;
            fifo_mem_q  <= fifo_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_valid_q  <= wr_valid_d;
            wr_job_q    <= wr_job_d;
            jobs_done_q <= jobs_done_d;
        end
    end

    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_job_q.addr;
    assign wr_data   = {448'b0, wr_job_q.prod};
    assign wr_req_id = wr_job_q.id;
    assign busy      = ((MULT_LAT > 1) && (|pipe_vld_q)) || (fifo_cnt_q != '0) || wr_valid_q;
    assign jobs_done = jobs_done_q;

endmodule

// File: tb/tb_mult_job_scheduler.sv
// Randomized and directed bench for mult_job_scheduler against a queue-based job model.
module tb_mult_job_scheduler;
    localparam int N  = 4;
    localparam int L  = 3;
    localparam int D  = 8;
    localparam int AW = 42;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*64-1:0]   req_a = '0;
    logic [N*64-1:0]   req_b = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic              c1_alm_full = 1'b0;
    logic              wr_valid;
    logic [AW-1:0]     wr_addr;
    logic [511:0]      wr_data;
    logic [1:0]        wr_req_id;
    logic              busy;
    logic [31:0]       jobs_done;

    always #5 clk = ~clk;

    mult_job_scheduler #(.NUM_REQ(N), .MULT_LAT(L), .RES_DEPTH(D), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_addr(req_addr), .c1_alm_full(c1_alm_full),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_req_id(wr_req_id),
        .busy(busy), .jobs_done(jobs_done)
    );

    // Model: jobs accepted but not yet popped, each ready to pop L cycles after accept.
    typedef struct {
        int unsigned   acc;
        logic [63:0]   prod;
        logic [AW-1:0] addr;
        logic [1:0]    id;
    } mjob_t;

    mjob_t         mq[$];
    int unsigned   cyc = 0;
    int            m_rr = 0;
    logic          m_wr_valid = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [63:0]   m_prod = '0;
    logic [1:0]    m_id = '0;
    logic [31:0]   m_done = '0;

    logic [N-1:0]  exp_ready;
    logic          exp_wr_valid, exp_busy;
    logic [AW-1:0] exp_addr;
    logic [511:0]  exp_data;
    logic [1:0]    exp_id;
    logic [31:0]   exp_done;
    int            exp_gnt;

    int errors = 0;
    int checks = 0;

    task automatic model_step();
        mjob_t j;
        if (reset) begin
            mq.delete();
            m_rr = 0; m_wr_valid = 1'b0; m_addr = '0; m_prod = '0; m_id = '0; m_done = '0;
        end
        exp_wr_valid = m_wr_valid;
        exp_addr     = m_addr;
        exp_data     = {448'b0, m_prod};
        exp_id       = m_id;
        exp_done     = m_done;
        exp_busy     = (mq.size() != 0) || m_wr_valid;
        exp_gnt      = -1;
        exp_ready    = '0;
        if (!reset && mq.size() < D) begin
            for (int i = 0; i < N; i++) begin
                int r;
                r = (m_rr + i) % N;
                if (exp_gnt < 0 && req_valid[r]) exp_gnt = r;
            end
        end
        if (exp_gnt >= 0) exp_ready[exp_gnt] = 1'b1;
        if (!reset) begin
            if (!c1_alm_full && mq.size() != 0 && mq[0].acc + L <= cyc) begin
                m_wr_valid = 1'b1;
                m_addr = mq[0].addr; m_prod = mq[0].prod; m_id = mq[0].id;
                m_done = m_done + 1;
                void'(mq.pop_front());
            end else begin
                m_wr_valid = 1'b0;
            end
            if (exp_gnt >= 0) begin
                j.acc  = cyc;
                j.prod = req_a[exp_gnt*64 +: 64] * req_b[exp_gnt*64 +: 64];
                j.addr = req_addr[exp_gnt*AW +: AW];
                j.id   = 2'(exp_gnt);
                mq.push_back(j);
                m_rr = (exp_gnt + 1) % N;
            end
        end
        cyc++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic drain(input int n);
        req_valid = '0;
        c1_alm_full = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk); model_step();
            checks++; if (wr_valid !== exp_wr_valid) begin errors++; $display("FAIL drain_wr_valid got=%b exp=%b", wr_valid, exp_wr_valid); end
            checks++; if (jobs_done !== exp_done) begin errors++; $display("FAIL drain_jobs_done got=%0d exp=%0d", jobs_done, exp_done); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL drain_busy got=%b exp=%b", busy, exp_busy); end
            next_cycle();
        end
    endtask

    task automatic test_reset();
        req_valid = '1;
        @(negedge clk); model_step();
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
        checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got=%h exp=0", wr_data[63:0]); end
        checks++; if (wr_req_id !== '0) begin errors++; $display("FAIL reset_wr_req_id got=%0d exp=0", wr_req_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (jobs_done !== '0) begin errors++; $display("FAIL reset_jobs_done got=%0d exp=0", jobs_done); end
        next_cycle();
        reset = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single_job();
        req_a[2*64 +: 64] = 64'd7;
        req_b[2*64 +: 64] = 64'd6;
        req_addr[2*AW +: AW] = 42'h100;
        req_valid = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); model_step();
            if (k == 0) begin
                checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
            end
            checks++; if (wr_valid !== exp_wr_valid) begin errors++; $display("FAIL single_wr_valid k=%0d got=%b exp=%b", k, wr_valid, exp_wr_valid); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, busy, exp_busy); end
            if (k == 4) begin
                checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL single_latency got=%b exp=1", wr_valid); end
                checks++; if (wr_data !== 512'd42) begin errors++; $display("FAIL single_data got=%h exp=42", wr_data[63:0]); end
                checks++; if (wr_addr !== 42'h100) begin errors++; $display("FAIL single_addr got=%h exp=100", wr_addr); end
                checks++; if (wr_req_id !== 2'd2) begin errors++; $display("FAIL single_id got=%0d exp=2", wr_req_id); end
                checks++; if (jobs_done !== 32'd1) begin errors++; $display("FAIL single_jobs_done got=%0d exp=1", jobs_done); end
            end
            if (k == 6) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall got=%b exp=0", busy); end
            end
            next_cycle();
            req_valid = '0;
        end
    endtask

    task automatic test_truncation();
        int seen = 0;
        req_a[1*64 +: 64] = '1;
        req_b[1*64 +: 64] = '1;
        req_addr[1*AW +: AW] = 42'h2A5;
        req_valid = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); model_step();
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL trunc_ready got=%b exp=%b", req_ready, exp_ready); end
            if (wr_valid) begin
                seen++;
                checks++; if (wr_data[63:0] !== 64'd1) begin errors++; $display("FAIL trunc_low got=%h exp=1", wr_data[63:0]); end
                checks++; if (wr_data[511:64] !== '0) begin errors++; $display("FAIL trunc_high got=%h exp=0", wr_data[127:64]); end
                checks++; if (wr_data !== exp_data) begin errors++; $display("FAIL trunc_model got=%h exp=%h", wr_data[63:0], exp_data[63:0]); end
            end
            next_cycle();
            req_valid = '0;
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL trunc_count got=%0d exp=1", seen); end
    endtask

    task automatic test_reset_midflight();
        int acc = 0;
        for (int r = 0; r < 3; r++) begin
            req_a[r*64 +: 64] = rnd64();
            req_b[r*64 +: 64] = rnd64();
            req_addr[r*AW +: AW] = AW'(32'h300 + r);
        end
        req_valid = 4'b0111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); model_step();
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL mid_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready); end
            if (req_ready != '0) acc++;
            next_cycle();
            if (k == 2) req_valid = '0;
        end
        checks++; if (acc != 3) begin errors++; $display("FAIL mid_accepts got=%0d exp=3", acc); end
        reset = 1'b1;
        req_valid = '1;
        @(negedge clk); model_step();
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL mid_rst_ready got=%b exp=0", req_ready); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_wr_valid got=%b exp=0", wr_valid); end
        checks++; if (wr_addr !== '0 || wr_data !== '0 || wr_req_id !== '0) begin
            errors++; $display("FAIL mid_rst_wr_fields got=%h/%h/%0d exp=0/0/0", wr_addr, wr_data[63:0], wr_req_id);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        checks++; if (jobs_done !== '0) begin errors++; $display("FAIL mid_rst_jobs_done got=%0d exp=0", jobs_done); end
        next_cycle();
        reset = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); model_step();
            checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL mid_ghost_write k=%0d got=%b exp=0", k, wr_valid); end
            checks++; if (jobs_done !== '0) begin errors++; $display("FAIL mid_jobs_done k=%0d got=%0d exp=0", k, jobs_done); end
            next_cycle();
        end
    endtask

    task automatic test_round_robin();
        int cnt[N];
        for (int r = 0; r < N; r++) cnt[r] = 0;
        req_valid = '1;
        for (int k = 0; k < 16; k++) begin
            for (int r = 0; r < N; r++) begin
                req_a[r*64 +: 64] = rnd64();
                req_b[r*64 +: 64] = rnd64();
                req_addr[r*AW +: AW] = AW'($urandom);
            end
            @(negedge clk); model_step();
            checks++; if (req_ready !== 4'(1 << (k % N))) begin errors++; $display("FAIL rr_order k=%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % N))); end
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_model k=%0d got=%b exp=%b", k, req_ready, exp_ready); end
            checks++; if (wr_valid !== exp_wr_valid || wr_req_id !== exp_id || wr_data !== exp_data) begin
                errors++; $display("FAIL rr_write k=%0d got=%b/%0d/%h exp=%b/%0d/%h", k, wr_valid, wr_req_id, wr_data[63:0], exp_wr_valid, exp_id, exp_data[63:0]);
            end
            for (int r = 0; r < N; r++) if (req_ready[r]) cnt[r]++;
            next_cycle();
        end
        for (int r = 0; r < N; r++) begin
            checks++; if (cnt[r] != 4) begin errors++; $display("FAIL rr_fairness req=%0d got=%0d exp=4", r, cnt[r]); end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int grants = 0;
        c1_alm_full = 1'b1;
        req_valid = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            req_a[63:0] = rnd64();
            req_b[63:0] = rnd64();
            req_addr[AW-1:0] = AW'(k);
            @(negedge clk); model_step();
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL bp_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready); end
            checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL bp_held_write k=%0d got=%b exp=0", k, wr_valid); end
            if (k >= 8) begin
                checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_credit k=%0d got=%b exp=0", k, req_ready); end
            end
            if (req_ready[0]) acc++;
            next_cycle();
        end
        checks++; if (acc != 8) begin errors++; $display("FAIL bp_accepts got=%0d exp=8", acc); end
        c1_alm_full = 1'b0;
        for (int k = 0; k < 20; k++) begin
            req_a[63:0] = rnd64();
            req_b[63:0] = rnd64();
            req_addr[AW-1:0] = AW'(100 + k);
            @(negedge clk); model_step();
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL bp_rel_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready); end
            checks++; if (wr_valid !== exp_wr_valid || wr_addr !== exp_addr || wr_data !== exp_data) begin
                errors++; $display("FAIL bp_rel_write k=%0d got=%b/%h/%h exp=%b/%h/%h", k, wr_valid, wr_addr, wr_data[63:0], exp_wr_valid, exp_addr, exp_data[63:0]);
            end
            if (k >= 1 && k <= 8) begin
                checks++; if (wr_valid !== 1'b1 || wr_addr !== AW'(k - 1)) begin
                    errors++; $display("FAIL bp_burst k=%0d got=%b/%h exp=1/%h", k, wr_valid, wr_addr, AW'(k - 1));
                end
            end
            if (req_ready[0]) grants++;
            next_cycle();
        end
        checks++; if (grants == 0) begin errors++; $display("FAIL bp_resume got=%0d exp=>0", grants); end
        drain(20);
    endtask

    task automatic test_counter_wrap();
        force dut.jobs_done_q = 32'hFFFF_FFFF;
        #1;
        release dut.jobs_done_q;
        m_done = 32'hFFFF_FFFF;
        req_a[3*64 +: 64] = rnd64();
        req_b[3*64 +: 64] = rnd64();
        req_addr[3*AW +: AW] = 42'h3FF;
        req_valid = 4'b1000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); model_step();
            checks++; if (jobs_done !== exp_done) begin errors++; $display("FAIL wrap_model k=%0d got=%h exp=%h", k, jobs_done, exp_done); end
            if (wr_valid) begin
                checks++; if (jobs_done !== 32'd0) begin errors++; $display("FAIL wrap_zero got=%h exp=0", jobs_done); end
            end
            next_cycle();
            req_valid = '0;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            req_valid = N'($urandom);
            for (int r = 0; r < N; r++) begin
                req_a[r*64 +: 64] = rnd64();
                req_b[r*64 +: 64] = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15)) : rnd64();
                req_addr[r*AW +: AW] = AW'(rnd64());
            end
            c1_alm_full = ($urandom_range(0, 3) == 0);
            @(negedge clk); model_step();
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready); end
            checks++; if (wr_valid !== exp_wr_valid) begin errors++; $display("FAIL rand_wr_valid k=%0d got=%b exp=%b", k, wr_valid, exp_wr_valid); end
            checks++; if (wr_addr !== exp_addr || wr_data !== exp_data || wr_req_id !== exp_id) begin
                errors++; $display("FAIL rand_write k=%0d got=%h/%h/%0d exp=%h/%h/%0d", k, wr_addr, wr_data[63:0], wr_req_id, exp_addr, exp_data[63:0], exp_id);
            end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy k=%0d got=%b exp=%b", k, busy, exp_busy); end
            checks++; if (jobs_done !== exp_done) begin errors++; $display("FAIL rand_jobs_done k=%0d got=%0d exp=%0d", k, jobs_done, exp_done); end
            next_cycle();
        end
        drain(30);
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_truncation();
        test_reset_midflight();
        test_round_robin();
        drain(10);
        test_backpressure();
        test_counter_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
